// File: rtl/if_stage_if.sv
// if_stage_if: bundles the fetch-stage side signals (redirect/stall
// controls, instruction ROM bus and IF/ID register outputs).
// master = the fetch stage, slave = the surrounding pipeline and ROM.
// Optional id_except member exists only when IF_EXCEPT_EN is defined.
interface if_stage_if;
  logic        stall_if;
  logic        stall_id;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic [31:0] inst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
`ifdef IF_EXCEPT_EN
  logic        id_except;
`endif

  modport master (
    input  stall_if, stall_id, flush, new_pc, branch_flag, branch_target, inst,
`ifdef IF_EXCEPT_EN
    output id_except,
`endif
    output rom_ce, rom_addr, id_pc, id_inst, id_valid
  );

  modport slave (
    output stall_if, stall_id, flush, new_pc, branch_flag, branch_target, inst,
`ifdef IF_EXCEPT_EN
    input  id_except,
`endif
    input  rom_ce, rom_addr, id_pc, id_inst, id_valid
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage. Owns the PC, drives the instruction
// ROM, and captures the fetched instruction into the IF/ID register.
// Optional feature macro: IF_EXCEPT_EN (misaligned-fetch flag on id_except;
// when undefined, redirect targets are forced word-aligned).
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RESET | held in / just out of reset, ROM disabled, PC = RESET_PC
// ST_RUN   | fetching, rom_ce = 1, PC advances / redirects / holds
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic       clk,
  input logic       rst,
  if_stage_if.master bus
);

  typedef enum logic {ST_RESET = 1'b0, ST_RUN = 1'b1} state_t;

  state_t      state;
  logic [31:0] pc;
  logic        rom_ce_q;
  logic [31:0] id_pc_q;
  logic [31:0] id_inst_q;
  logic        id_valid_q;
`ifdef IF_EXCEPT_EN
  logic        id_except_q;
`endif

  // A stall from decode alone still has to freeze the PC, otherwise the
  // instruction it is holding would be lost.
  logic hold_pc;
  assign hold_pc = bus.stall_if | bus.stall_id;

`ifdef IF_EXCEPT_EN
  function automatic logic [31:0] align_target(input logic [31:0] t);
    return t;
  endfunction
`else
  function automatic logic [31:0] align_target(input logic [31:0] t);
    return t & 32'hFFFF_FFFC;
  endfunction
`endif

  // PC state machine and IF/ID pipeline register, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_RESET;
      pc          <= RESET_PC;
      rom_ce_q    <= 1'b0;
      id_pc_q     <= 32'h0;
      id_inst_q   <= 32'h0;
      id_valid_q  <= 1'b0;
`ifdef IF_EXCEPT_EN
      id_except_q <= 1'b0;
`endif
    end else begin
      case (state)
        ST_RESET: begin
          state    <= ST_RUN;
          pc       <= RESET_PC;
          rom_ce_q <= 1'b1;
        end
        ST_RUN: begin
          if (bus.flush)
            pc <= align_target(bus.new_pc);
          else if (!hold_pc) begin
            if (bus.branch_flag)
              pc <= align_target(bus.branch_target);
            else
              pc <= pc + 32'd4;
          end
        end
        default: begin
          state    <= ST_RESET;
          pc       <= RESET_PC;
          rom_ce_q <= 1'b0;
        end
      endcase

      if (bus.flush || (bus.stall_if && !bus.stall_id)) begin
        id_pc_q     <= 32'h0;
        id_inst_q   <= 32'h0;
        id_valid_q  <= 1'b0;
`ifdef IF_EXCEPT_EN
        id_except_q <= 1'b0;
`endif
      end else if (!bus.stall_id) begin
        id_pc_q <= pc;
`ifdef IF_EXCEPT_EN
        if (pc[1:0] != 2'b00) begin
          id_inst_q   <= 32'h0;
          id_valid_q  <= 1'b1;
          id_except_q <= 1'b1;
        end else begin
          id_inst_q   <= bus.inst;
          id_valid_q  <= rom_ce_q;
          id_except_q <= 1'b0;
        end
`else
        id_inst_q  <= bus.inst;
        id_valid_q <= rom_ce_q;
`endif
      end
    end
  end

  assign bus.rom_ce    = rom_ce_q;
  assign bus.rom_addr  = pc;
  assign bus.id_pc     = id_pc_q;
  assign bus.id_inst   = id_inst_q;
  assign bus.id_valid  = id_valid_q;
`ifdef IF_EXCEPT_EN
  assign bus.id_except = id_except_q;
`endif

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the five-stage pipeline. Owns the program counter, drives the chip-enable and byte address of the instruction ROM, and captures the returned instruction into the IF/ID pipeline register for the decode stage. Handles pipeline stalls from the control unit, branch redirects from decode, and flush redirects from the exception unit.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset; bits [1:0] must be 00.

- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_if  input  1  hold PC; no new fetch is accepted into IF/ID.
- stall_id  input  1  decode stalled; hold IF/ID contents.
- flush  input  1  exception/eret redirect; highest priority.
- new_pc  input  32  redirect target used when flush=1.
- branch_flag  input  1  taken branch resolved in decode.
- branch_target  input  32  target used when branch_flag=1.
- inst  input  32  ROM read data; combinational from rom_addr/rom_ce.
- rom_ce  output  1  ROM chip enable, 1 = enabled.
- rom_addr  output  32  fetch byte address (current PC).
- id_pc  output  32  PC of the instruction held in IF/ID.
- id_inst  output  32  instruction held in IF/ID; 0 = bubble (nop).
- id_valid  output  1  IF/ID holds a real fetched instruction.
- id_except  output  1  misaligned fetch flag (present only with IF_EXCEPT_EN).

## Operation
- PC states: RESET (rom_ce=0), RUN (rom_ce=1). rst forces RESET. The first rising edge with rst=0 enters RUN with PC=RESET_PC, and the PC does not advance on that edge. The stage stays in RUN until rst.
- PC update on each edge in RUN, highest priority first:
  - flush: PC=new_pc.
  - stall_if: hold.
  - branch_flag: PC=branch_target.
  - otherwise: PC=PC+4, 32-bit wrap (0xFFFF_FFFC goes to 0x0000_0000).
- rom_addr=PC at all times. rom_ce=1 only in RUN.
- IF/ID update on each edge, highest priority first:
  - rst: clear.
  - flush: bubble (id_pc=0, id_inst=0, id_valid=0).
  - stall_if=1 and stall_id=0: bubble.
  - stall_if=1 and stall_id=1: hold.
  - stall_if=0: load id_pc=PC, id_inst=inst, id_valid=rom_ce.
- stall_id=1 with stall_if=0 is illegal. It is treated as stall_if=1.
- branch_flag during stall_if is ignored. Decode re-presents it once unstalled.
- flush overrides simultaneous stall and branch on both PC and IF/ID.

## Timing
- Reset values, asynchronous and immediate: rom_ce=0, rom_addr=RESET_PC, id_pc=0, id_inst=0, id_valid=0, id_except=0.
- Fetch-to-decode latency is 1 cycle. The instruction addressed during cycle n appears on id_inst after edge n.
- Redirect latency is 1 cycle. The target appears on rom_addr after the edge where flush or branch_flag is sampled.
- Reset asserted mid-operation clears all state without waiting for clk. Deassertion restarts at RESET.

## Configuration
- IF_EXCEPT_EN defined:
  - The id_except port exists.
  - new_pc and branch_target are loaded unmodified.
  - If PC[1:0]≠00 when IF/ID loads, id_inst=0, id_valid=1 and id_except=1, with id_pc=PC.
  - id_except clears with bubbles and holds with hold.
- IF_EXCEPT_EN undefined:
  - No id_except port.
  - Bits [1:0] of loaded targets are forced to 00, so PC is always word-aligned.

## Test plan
- Reset release: rst=1 for 3 cycles, then 0.
  - During reset: rom_ce=0, rom_addr=0.
  - After the 1st edge: rom_ce=1, rom_addr=0.
  - Then rom_addr=4, 8. id_pc follows 1 cycle behind, with id_valid=1 from 2nd edge.
- Full stall: at PC=0x8, stall_if=stall_id=1 for 2 cycles.
  - rom_addr holds 0x8 and IF/ID holds id_pc=0x4.
  - On release, rom_addr=0xC and id_pc=0x8.
- Bubble: stall_if=1, stall_id=0 for 1 cycle at PC=0x10.
  - id_inst=0, id_valid=0, rom_addr stays 0x10.
  - Next edge: id_pc=0x10.
- Branch: branch_flag=1, branch_target=0x100 at PC=0x14.
  - Next rom_addr=0x100, then 0x104. id_pc=0x14 then 0x100.
- Flush priority: flush=1 with new_pc=0x20, plus branch_flag=1 (target 0x100) and stall_if=1 in the same cycle.
  - rom_addr=0x20, IF/ID bubble.
- Async reset mid-run: rst rises between edges at PC=0x40.
  - All outputs reach reset values before the next edge.
- IF_EXCEPT_EN: branch_target=0x102.
  - id_pc=0x102, id_inst=0, id_except=1, id_valid=1.
  - Without the macro, rom_addr=0x100.
